// File: rtl/trisc_loader_if.sv
// trisc_loader_if: byte-stream handshake into the loader and the RAM
// write bus coming out of it. The slave modport is the loader side; the
// master modport is the stream producer / RAM observer side.
interface trisc_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_addr, ram_data, ram_wren
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_addr, ram_data, ram_wren
  );
endinterface

// File: rtl/trisc_loader.sv
// trisc_loader: receives a program image as a byte stream (header N, then
// N data bytes), writes it into the 16-word TRISC RAM through the load-mode
// path and releases the core with a one-cycle cpu_start pulse.
// Optional feature macro: TRISC_LOADER_CHECKSUM_EN adds a trailing 8-bit
// checksum byte (sum of data bytes mod 256); a mismatch ends in the error
// state instead of starting the core.
module trisc_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic           sysclock,
  input  logic           sysreset,
  input  logic           load,
  trisc_loader_if.slave  bus,
  output logic           load_mode,
  output logic           cpu_start,
  output logic           busy,
  output logic           done,
  output logic           error
);

`ifdef TRISC_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    st_idle, st_hdr, st_data, st_drain, st_start, st_err, st_csum
  } state_t;
`else
  typedef enum logic [2:0] {
    st_idle, st_hdr, st_data, st_drain, st_start, st_err
  } state_t;
`endif

  state_t state_reg, state_next;

  // Word count and index are one bit wider than the address so that a
  // full 16-word image can be represented.
  logic [ADDR_W:0]   count_reg, count_next;
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              wren_reg, wren_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;
`ifdef TRISC_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg, sum_next;
`endif

  logic in_ready_int;
  logic accept;
  logic hdr_ok;
  logic last_byte;

  // Next-state logic, datapath next values and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wren_next  = 1'b0;
    done_next  = done_reg;
    error_next = error_reg;
`ifdef TRISC_LOADER_CHECKSUM_EN
    sum_next   = sum_reg;
`endif

    in_ready_int = (state_reg == st_hdr) || (state_reg == st_data)
`ifdef TRISC_LOADER_CHECKSUM_EN
                   || (state_reg == st_csum)
`endif
                   ;
    load_mode = in_ready_int || (state_reg == st_drain);
    cpu_start = (state_reg == st_start);
    busy      = (state_reg != st_idle);

    accept    = bus.in_valid && in_ready_int;
    hdr_ok    = (bus.in_data != '0) && (bus.in_data <= DATA_W'(MAX_WORDS));
    last_byte = ((idx_reg + (ADDR_W+1)'(1)) == count_reg);

    case (state_reg)
      st_idle: begin
        if (load) begin
          state_next = st_hdr;
          idx_next   = '0;
          done_next  = 1'b0;
          error_next = 1'b0;
`ifdef TRISC_LOADER_CHECKSUM_EN
          sum_next   = '0;
`endif
        end
      end
      st_hdr: begin
        if (accept) begin
          if (hdr_ok) begin
            count_next = bus.in_data[ADDR_W:0];
            state_next = st_data;
          end else begin
            // Flag is raised on the transition so it is visible in the
            // first cycle after the bad header.
            error_next = 1'b1;
            state_next = st_err;
          end
        end
      end
      st_data: begin
        if (accept) begin
          addr_next = idx_reg[ADDR_W-1:0];
          data_next = bus.in_data;
          wren_next = 1'b1;
          idx_next  = idx_reg + (ADDR_W+1)'(1);
`ifdef TRISC_LOADER_CHECKSUM_EN
          sum_next  = sum_reg + bus.in_data;
          if (last_byte) state_next = st_csum;
`else
          if (last_byte) state_next = st_drain;
`endif
        end
      end
      // Holds load_mode for the cycle in which the last write lands.
      st_drain: begin
        state_next = st_start;
        done_next  = 1'b1;
      end
`ifdef TRISC_LOADER_CHECKSUM_EN
      st_csum: begin
        if (accept) begin
          if (bus.in_data == sum_reg) begin
            state_next = st_start;
            done_next  = 1'b1;
          end else begin
            state_next = st_err;
            error_next = 1'b1;
          end
        end
      end
`endif
      st_start: state_next = st_idle;
      st_err:   state_next = st_idle;
      default:  state_next = st_idle;
    endcase
  end

  // State register.
  always_ff @(posedge sysclock) begin
    if (sysreset) state_reg <= st_idle;
    else          state_reg <= state_next;
  end

  // Datapath registers: counters, registered RAM write port, sticky flags.
  always_ff @(posedge sysclock) begin
    if (sysreset) begin
      count_reg <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      wren_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
`ifdef TRISC_LOADER_CHECKSUM_EN
      sum_reg   <= '0;
`endif
    end else begin
      count_reg <= count_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      wren_reg  <= wren_next;
      done_reg  <= done_next;
      error_reg <= error_next;
`ifdef TRISC_LOADER_CHECKSUM_EN
      sum_reg   <= sum_next;
`endif
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.ram_addr = addr_reg;
  assign bus.ram_data = data_reg;
  assign bus.ram_wren = wren_reg;
  assign done         = done_reg;
  assign error        = error_reg;

endmodule
